// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: system byte stream plus UART transmit load port seen by the feeder.
interface uart_tx_feeder_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] uart_din;
  logic                  uart_din_vld;
  logic                  uart_rfd;
  logic                  busy;
  modport master (output s_data, s_valid, uart_rfd, input s_ready, uart_din, uart_din_vld, busy);
  modport slave (input s_data, s_valid, uart_rfd, output s_ready, uart_din, uart_din_vld, busy);
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered writer for the UART transmit port, paced by rfd.
// Defining UART_TXQ_LEVEL_EN adds the registered occupancy port level_o.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_feeder_if.slave io
`ifdef UART_TXQ_LEVEL_EN
  , output logic [$clog2(DEPTH):0] level_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT_BUSY} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic vld_q, vld_d, full, empty, push, pop;
  assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign push     = io.s_valid && !full;
  assign pop      = state_q == IDLE && !empty && io.uart_rfd;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= io.s_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  // WAIT_BUSY holds until rfd drops, so a late rfd cannot trigger a second load
  always_comb
    state_d = state_q == IDLE ? (pop ? WAIT_BUSY : IDLE) : (io.uart_rfd ? WAIT_BUSY : IDLE);
  always_comb begin
    vld_d = pop;
    din_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : din_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      din_q <= '0;
      vld_q <= 1'b0;
    end else begin
      din_q <= din_d;
      vld_q <= vld_d;
    end
  assign io.s_ready      = !full;
  assign io.uart_din     = din_q;
  assign io.uart_din_vld = vld_q;
  assign io.busy         = !empty || state_q == WAIT_BUSY;
`ifdef UART_TXQ_LEVEL_EN
  logic [AW:0] level_q, level_d;
  always_comb level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  always_ff @(posedge clk or negedge rst)
    if (!rst) level_q <= '0;
    else      level_q <= level_d;
  assign level_o = level_q;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks of uart_tx_feeder against a queue-based model.
module tb_uart_tx_feeder;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_tx_feeder_if #(.DATA_WIDTH(DW)) bus();
`ifdef UART_TXQ_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif
  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
`ifdef UART_TXQ_LEVEL_EN
    , .level_o(level)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_din;
  bit exp_vld, waiting, last_push, u_auto;
  int u_cnt, u_frame, u_lag_max, loads, pops;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("uart_din", bus.uart_din, exp_din);
    chk("uart_din_vld", bus.uart_din_vld, exp_vld);
    chk("busy", bus.busy, (q.size() > 0 || waiting));
    chk("s_ready", bus.s_ready, (q.size() < DEPTH));
`ifdef UART_TXQ_LEVEL_EN
    chk("level", level, q.size());
`endif
  endtask

  task automatic model_reset();
    q.delete();
    waiting = 0;
    exp_din = '0;
    exp_vld = 0;
  endtask

  // One clock: model reacts to the inputs present at the edge, then outputs are compared.
  task automatic step();
    bit push, pop;
    push = bus.s_valid && q.size() < DEPTH;
    pop  = !waiting && q.size() > 0 && bus.uart_rfd;
    @(posedge clk);
    #1;
    if (pop) begin
      exp_din = q.pop_front();
      pops++;
    end
    if (push) q.push_back(bus.s_data);
    waiting = pop || (waiting && bus.uart_rfd);
    exp_vld = pop;
    last_push = push;
    check_outputs();
    if (bus.uart_din_vld) loads++;
    if (u_auto) begin
      if (bus.uart_din_vld) begin
        u_frame = $urandom_range(1, 5);
        u_cnt = $urandom_range(0, u_lag_max) + u_frame;
      end else if (u_cnt > 0) u_cnt--;
      bus.uart_rfd = u_cnt == 0 || u_cnt > u_frame;
    end
  endtask

  task automatic auto_on();
    u_auto = 1;
    u_frame = 3;
    u_cnt = waiting ? 3 : 0;
    bus.uart_rfd = u_cnt == 0;
  endtask

  task automatic push_byte(logic [DW-1:0] b);
    bus.s_valid = 1;
    bus.s_data = b;
    last_push = 0;
    for (int i = 0; i < 200 && !last_push; i++) step();
    bus.s_valid = 0;
    chk("push_accepted", last_push, 1);
  endtask

  task automatic drain();
    auto_on();
    for (int i = 0; i < 400 && (q.size() > 0 || waiting || !bus.uart_rfd); i++) step();
    chk("drain_busy", bus.busy, 0);
  endtask

  initial begin
    bus.s_valid = 0;
    bus.s_data = '0;
    bus.uart_rfd = 0;
    u_auto = 0;
    u_lag_max = 0;
    loads = 0;
    pops = 0;
    model_reset();
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    // single byte
    bus.uart_rfd = 1;
    push_byte(8'hA5);
    step();
    chk("single_vld", bus.uart_din_vld, 1);
    chk("single_din", bus.uart_din, 8'hA5);
    step();
    bus.uart_rfd = 0;
    step();
    chk("single_busy", bus.busy, 0);
    bus.uart_rfd = 1;
    step();
    // fill with rfd held low
    bus.uart_rfd = 0;
    for (int b = 0; b < 16; b++) push_byte(DW'(b));
    chk("fill_ready", bus.s_ready, 0);
`ifdef UART_TXQ_LEVEL_EN
    chk("fill_level", level, 16);
`endif
    bus.s_valid = 1;
    bus.s_data = 8'h10;
    repeat (3) step();
    auto_on();
    push_byte(8'h10);
    drain();
    // simultaneous push and pop at 15 entries
    u_auto = 0;
    bus.uart_rfd = 0;
    for (int i = 0; i < 15; i++) push_byte(DW'($urandom));
    bus.s_valid = 1;
    bus.s_data = 8'hC3;
    bus.uart_rfd = 1;
    step();
    bus.s_valid = 0;
    chk("simul_vld", bus.uart_din_vld, 1);
    chk("simul_ready", bus.s_ready, 1);
`ifdef UART_TXQ_LEVEL_EN
    chk("simul_level", level, 15);
`endif
    drain();
    // random traffic with rfd lagging the strobe by up to 2 cycles
    u_lag_max = 2;
    auto_on();
    for (int i = 0; i < 300; i++) begin
      if (!bus.s_valid || last_push) begin
        bus.s_valid = $urandom_range(0, 1) == 1;
        bus.s_data = DW'($urandom);
      end
      step();
    end
    bus.s_valid = 0;
    drain();
    chk("load_count", loads, pops);
    // reset with five bytes queued and a handoff pending
    u_auto = 0;
    bus.uart_rfd = 0;
    for (int i = 0; i < 6; i++) push_byte(DW'($urandom));
    bus.uart_rfd = 1;
    step();
    chk("pre_rst_busy", bus.busy, 1);
    #2;
    rst = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    repeat (5) step();
    push_byte(8'h3C);
    step();
    chk("post_rst_din", bus.uart_din, 8'h3C);
    chk("post_rst_vld", bus.uart_din_vld, 1);
    drain();
    chk("final_loads", loads, pops);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
